// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests and buffers {pc, instruction} for IF/ID.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the outputs when the buffer is empty.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      pc_q;
    logic [CNT_W-1:0] outstanding_q, kill_q, count_q;
    logic [CNT_W-1:0] outstanding_d, kill_d, count_d;
    logic [PTR_W-1:0] inf_rd_q, inf_wr_q, buf_rd_q, buf_wr_q;
    logic [31:0]      inf_pc_q  [DEPTH];
    logic [31:0]      buf_pc_q  [DEPTH];
    logic [31:0]      buf_ins_q [DEPTH];

    logic             accept, resp, resp_live, buf_empty, push, pop;
    logic [31:0]      resp_pc;
    logic [SUM_W-1:0] credits_used;

    // Issue credits, response qualification and IF/ID-facing outputs.
    always_comb begin
        credits_used   = SUM_W'(outstanding_q) + SUM_W'(count_q);
        imem_req_valid = reset && !branch && (credits_used < SUM_W'(DEPTH));
        imem_req_addr  = pc_q;
        accept         = imem_req_valid && imem_req_ready;
        resp           = imem_resp_valid && (outstanding_q != '0);
        resp_live      = resp && (kill_q == '0);
        resp_pc        = inf_pc_q[inf_rd_q];
        buf_empty      = (count_q == '0);
        pop            = !buf_empty && !stall && !branch;
`ifdef FETCH_BYPASS_EN
        valid_out       = !buf_empty || resp_live;
        pc_out          = !buf_empty ? buf_pc_q[buf_rd_q]  : (resp_live ? resp_pc : '0);
        instruction_out = !buf_empty ? buf_ins_q[buf_rd_q] : (resp_live ? imem_resp_data : '0);
        // A bypassed response consumed this cycle never occupies a buffer slot.
        push            = resp_live && !branch && !(buf_empty && !stall);
`else
        valid_out       = !buf_empty;
        pc_out          = buf_empty ? '0 : buf_pc_q[buf_rd_q];
        instruction_out = buf_empty ? '0 : buf_ins_q[buf_rd_q];
        push            = resp_live && !branch;
`endif
    end

    // Saturating counters; after a redirect every request still in flight is dead.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !resp && (outstanding_q != CNT_W'(DEPTH)))
            outstanding_d = outstanding_q + CNT_W'(1);
        else if (resp && !accept)
            outstanding_d = outstanding_q - CNT_W'(1);

        kill_d = kill_q;
        if (branch)
            kill_d = outstanding_d;
        else if (resp && (kill_q != '0))
            kill_d = kill_q - CNT_W'(1);

        count_d = count_q;
        if (branch)
            count_d = '0;
        else if (push && !pop && (count_q != CNT_W'(DEPTH)))
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
    end

    // Killed responses still retire their in-flight slot, keeping the PC FIFO aligned with outstanding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
            count_q       <= '0;
            inf_rd_q      <= '0;
            inf_wr_q      <= '0;
            buf_rd_q      <= '0;
            buf_wr_q      <= '0;
        end else begin
            if (branch)
                pc_q <= branch_target & ~32'd3;
            else if (accept)
                pc_q <= pc_q + 32'd4;
            if (accept)
                inf_wr_q <= inf_wr_q + PTR_W'(1);
            if (resp)
                inf_rd_q <= inf_rd_q + PTR_W'(1);
            if (branch)
                buf_rd_q <= buf_wr_q;
            else if (pop)
                buf_rd_q <= buf_rd_q + PTR_W'(1);
            if (push)
                buf_wr_q <= buf_wr_q + PTR_W'(1);
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            count_q       <= count_d;
        end
    end

    // Storage arrays carry no control meaning, so they need no reset.
    always_ff @(posedge clock) begin
        if (accept)
            inf_pc_q[inf_wr_q] <= pc_q;
        if (push) begin
            buf_pc_q[buf_wr_q]  <= resp_pc;
            buf_ins_q[buf_wr_q] <= imem_resp_data;
        end
    end

    // A response with nothing outstanding is dropped by the resp qualifier; flag it in simulation.
    assert property (@(posedge clock) disable iff (!reset) imem_resp_valid |-> (outstanding_q != '0))
        else $warning("fetch_stage: imem response with nothing outstanding ignored");

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: queue-based reference model, latency-randomized memory,
// and a scoreboard monitor that checks every instruction IF/ID consumes.
module tb_fetch_stage;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset, stall, branch, imem_req_ready, imem_resp_valid;
    logic        imem_req_valid, valid_out;
    logic [31:0] branch_target, imem_resp_data, imem_req_addr, pc_out, instruction_out;

    always #5 clock = ~clock;

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .stall(stall), .branch(branch),
        .branch_target(branch_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .valid_out(valid_out), .pc_out(pc_out), .instruction_out(instruction_out)
    );

    typedef struct { logic [31:0] pc; logic [31:0] ins; } entry_t;
    typedef struct { logic [31:0] pc; bit killed; }       req_t;
    typedef struct { logic [31:0] data; int cyc; }        mem_t;

    req_t        inflight[$];
    entry_t      bufq[$];
    entry_t      exp_q[$];
    mem_t        mem_q[$];
    logic [31:0] m_pc;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one cycle of the fetch rules, evaluated after inputs settle.
    task automatic model_cycle(input logic st, input logic br, input logic [31:0] tgt, input logic rdy);
        logic   exp_rv, have_resp, consume, from_buf;
        entry_t head;
        logic   head_v;
        req_t   r;
        mem_t   m;

        exp_rv = !br && (inflight.size() + bufq.size() < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);

        have_resp = imem_resp_valid;
        head_v    = 1'b0;
        head      = '{pc: 32'h0, ins: 32'h0};
        from_buf  = bufq.size() > 0;
        if (from_buf) begin
            head_v = 1'b1;
            head   = bufq[0];
        end
`ifdef FETCH_BYPASS_EN
        else if (have_resp && !inflight[0].killed) begin
            head_v = 1'b1;
            head   = '{pc: inflight[0].pc, ins: imem_resp_data};
        end
`endif
        chk("valid_out", 32'(valid_out), 32'(head_v));
        chk("pc_out", pc_out, head.pc);
        chk("instruction_out", instruction_out, head.ins);

        consume = head_v && !st && !br;
        if (exp_q.size() != 0) begin
            chk("consume_missed", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        if (consume) exp_q.push_back(head);
        if (consume && from_buf) void'(bufq.pop_front());

        if (have_resp) begin
            r = inflight.pop_front();
            void'(mem_q.pop_front());
            if (!r.killed && !br && !(consume && !from_buf))
                bufq.push_back('{pc: r.pc, ins: imem_resp_data});
        end

        if (br) begin
            bufq.delete();
            foreach (inflight[i]) inflight[i].killed = 1'b1;
            m_pc = tgt & ~32'd3;
        end else if (exp_rv && rdy) begin
            inflight.push_back('{pc: m_pc, killed: 1'b0});
            m.data = $urandom;
            m.cyc  = cyc;
            mem_q.push_back(m);
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Drive one cycle at the falling edge; memory answers the oldest request at least one cycle later.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                        input logic rdy, input logic resp_en);
        @(negedge clock);
        stall          = st;
        branch         = br;
        branch_target  = tgt;
        imem_req_ready = rdy;
        if (resp_en && mem_q.size() > 0 && mem_q[0].cyc < cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].data;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        model_cycle(st, br, tgt, rdy);
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic reset_checks();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_instruction_out", instruction_out, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        stall = 1'b0; branch = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        #1;
        reset_checks();
        inflight.delete(); bufq.delete(); mem_q.delete(); exp_q.delete();
        m_pc = RESET_PC;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Scoreboard monitor: every instruction IF/ID takes must match the model's prediction.
    always @(negedge clock) begin
        entry_t e;
        #2;
        if (reset === 1'b1 && valid_out && !stall && !branch) begin
            chk("consume_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", pc_out, e.pc);
                chk("sb_instruction", instruction_out, e.ins);
            end
        end
    end

    logic        r_br;
    logic [31:0] r_tgt;
    int          r_sel;

    initial begin
        reset = 1'b0; stall = 1'b0; branch = 1'b0; branch_target = 32'h0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        m_pc = RESET_PC;
        cyc  = 0;
        #1;
        reset_checks();
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Fill from reset with a 1-cycle memory.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("first_addr", imem_req_addr, 32'h0100_0000);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Hold the head for five cycles while memory keeps answering.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect with two requests in flight; both must be discarded.
        drain(4);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0102, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("redirect_addr", imem_req_addr, 32'h0000_0100);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect while memory back-pressures: pending request is withdrawn.
        drain(4);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("withdraw_addr", imem_req_addr, 32'h0000_2000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // PC wrap at the top of the address space.
        drain(4);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Randomized traffic with a mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            r_br  = ($urandom_range(0, 15) == 0);
            r_sel = $urandom_range(0, 7);
            r_tgt = (r_sel == 0) ? 32'hFFFF_FFFF : (r_sel == 1) ? 32'h0000_0102 : 32'($urandom);
            step($urandom_range(0, 3) == 0, r_br, r_tgt,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            if (i == 1500) do_reset();
        end

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("final_buffer_empty", 32'(valid_out), 32'd0);
        @(negedge clock);
        #3;
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
